// File: rtl/ss_pkg.sv
// Shared definitions for the stochastic stream generator: FSM states,
// LFSR feedback masks and the default seed.
package ss_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } ss_state_e;

    // Galois feedback masks (polynomial without the x^N term), left-shifting form.
    // x^16 + x^15 + x^13 + x^4 + 1
    localparam logic [15:0] TAPS_N16 = 16'hA011;
    // x^8 + x^6 + x^5 + x^4 + 1
    localparam logic [15:0] TAPS_N8  = 16'h0071;

    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Feedback mask for a given LFSR width; only 8 and 16 are meaningful.
    function automatic logic [15:0] ss_taps(input int unsigned n);
        return (n == 8) ? TAPS_N8 : TAPS_N16;
    endfunction

endpackage

// File: rtl/ss_lfsr.sv
// Galois LFSR with synchronous reset to SEED, step enable, and an
// all-zero lock-up guard that reloads SEED.
module ss_lfsr
    import ss_pkg::*;
#(
    parameter int unsigned   N    = 16,
    parameter logic [N-1:0]  SEED = DEFAULT_SEED[N-1:0],
    parameter logic [N-1:0]  TAPS = TAPS_N16[N-1:0]
) (
    input  logic         CLK,
    input  logic         INIT,
    input  logic         EN,
    output logic [N-1:0] Q
);

    logic [N-1:0] r_q;
    logic [N-1:0] w_step;

    // One Galois step: shift toward MSB, fold the outgoing MSB back through the taps.
    always_comb begin
        w_step = {r_q[N-2:0], 1'b0} ^ (r_q[N-1] ? TAPS : '0);
    end

    // State register; the zero check catches any corruption into the dead state.
    always_ff @(posedge CLK) begin
        if (INIT) begin
            r_q <= SEED;
        end else if (r_q == '0) begin
            r_q <= SEED;
        end else if (EN) begin
            r_q <= w_step;
        end
    end

    assign Q = r_q;

endmodule

// File: rtl/ss_stream_gen.sv
// Stochastic bit-stream generator: emits LEN bits where each bit is 1 with
// probability VALUE/2^N, counting the ones produced.
module ss_stream_gen
    import ss_pkg::*;
#(
    parameter int unsigned  N     = 16,
    parameter int unsigned  LEN_W = 8,
    parameter logic [N-1:0] SEED  = DEFAULT_SEED[N-1:0]
) (
    input  logic             CLK,
    input  logic             INIT,
    input  logic [N-1:0]     VALUE,
    input  logic [LEN_W-1:0] LEN,
    input  logic             START,
    output logic             OUT,
    output logic             VALID,
    output logic             BUSY,
    output logic             DONE,
    output logic [LEN_W-1:0] ONES
);

    localparam logic [15:0]  TAPS_FULL = ss_taps(N);
    localparam logic [N-1:0] TAPS      = TAPS_FULL[N-1:0];

    ss_state_e        r_state;
    ss_state_e        w_state_next;
    logic [N-1:0]     r_value;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] r_ones;
    logic             r_out;
    logic             r_valid;

    logic             w_start_acc;
    logic [N-1:0]     w_cmp_value;
    logic [N-1:0]     w_lfsr_q;
    logic             w_lfsr_en;
    logic             w_bit;

    assign w_start_acc = (r_state == StIdle) && START;

    // The bit loaded on the START edge must use the incoming VALUE, not the stale capture.
    assign w_cmp_value = w_start_acc ? VALUE : r_value;

    // The LFSR steps once per emitted bit, on the edge that loads that bit into OUT,
    // so each stream consumes exactly LEN states and the next stream continues from there.
    assign w_lfsr_en = (w_state_next == StRun);

    ss_lfsr #(
        .N    (N),
        .SEED (SEED),
        .TAPS (TAPS)
    ) u_lfsr (
        .CLK  (CLK),
        .INIT (INIT),
        .EN   (w_lfsr_en),
        .Q    (w_lfsr_q)
    );

    // Comparator with the extremes pinned so probability 0 and ~1 are exact.
    always_comb begin
        w_bit = 1'b0;
        if (w_cmp_value == '1) begin
            w_bit = 1'b1;
        end else if (w_cmp_value == '0) begin
            w_bit = 1'b0;
        end else begin
            w_bit = (w_lfsr_q < w_cmp_value);
        end
    end

    // Next-state logic for IDLE -> RUN/DONE -> IDLE.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (START) begin
                    w_state_next = (LEN != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (r_rem == LEN_W'(1)) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State register and registered OUT/VALID so both change on the same edge.
    always_ff @(posedge CLK) begin
        if (INIT) begin
            r_state <= StIdle;
            r_valid <= 1'b0;
            r_out   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_valid <= (w_state_next == StRun);
            r_out   <= (w_state_next == StRun) && w_bit;
        end
    end

    // Stream capture, remaining-bit countdown and saturating ones counter.
    always_ff @(posedge CLK) begin
        if (INIT) begin
            r_value <= '0;
            r_rem   <= '0;
            r_ones  <= '0;
        end else if (w_start_acc) begin
            r_value <= VALUE;
            r_rem   <= LEN;
            r_ones  <= '0;
        end else begin
            if (r_state == StRun) begin
                r_rem <= r_rem - LEN_W'(1);
            end
            if (r_valid && r_out && (r_ones != '1)) begin
                r_ones <= r_ones + LEN_W'(1);
            end
        end
    end

    assign OUT   = r_out;
    assign VALID = r_valid;
    assign BUSY  = (r_state != StIdle);
    assign DONE  = (r_state == StDone);
    assign ONES  = r_ones;

endmodule

// File: tb/tb_ss_stream_gen.sv
// Scoreboard bench for ss_stream_gen (N=16, LEN_W=8): the driver pushes the
// expected bits and ones count from an independent LFSR model; a monitor pops
// and compares on every VALID and DONE cycle.
module tb_ss_stream_gen;

    logic        CLK;
    logic        INIT;
    logic [15:0] VALUE;
    logic [7:0]  LEN;
    logic        START;
    logic        OUT;
    logic        VALID;
    logic        BUSY;
    logic        DONE;
    logic [7:0]  ONES;

    int total = 0;
    int bad   = 0;

    logic        exp_bits[$];
    logic [7:0]  exp_ones[$];
    logic [15:0] m_lfsr;
    int          agg_model;
    int          agg_dut;

    ss_stream_gen #(
        .N     (16),
        .LEN_W (8),
        .SEED  (16'hACE1)
    ) dut (
        .CLK   (CLK),
        .INIT  (INIT),
        .VALUE (VALUE),
        .LEN   (LEN),
        .START (START),
        .OUT   (OUT),
        .VALID (VALID),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .ONES  (ONES)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // x^16 + x^15 + x^13 + x^4 + 1, feedback taken from the bit shifted out of the top.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] n;
        n = s << 1;
        if (s[15]) begin
            n[15] = ~n[15];
            n[13] = ~n[13];
            n[4]  = ~n[4];
            n[0]  = ~n[0];
        end
        return n;
    endfunction

    function automatic logic model_bit(input logic [15:0] v, input logic [15:0] s);
        if (v == 16'hFFFF) return 1'b1;
        if (v == 16'h0000) return 1'b0;
        return (s < v);
    endfunction

    // Monitor: compare every presented bit and every DONE against the scoreboard.
    initial begin
        logic       eb;
        logic [7:0] eo;
        forever begin
            @(negedge CLK);
            if (VALID === 1'b1) begin
                if (exp_bits.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    eb = exp_bits.pop_front();
                    check("out_bit", OUT, eb);
                end
            end
            if (DONE === 1'b1) begin
                if (exp_ones.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    eo = exp_ones.pop_front();
                    check("ones_at_done", ONES, eo);
                    check("bits_left_at_done", exp_bits.size(), 0);
                end
            end
        end
    end

    // Issue one stream; optionally pulse START again with another VALUE at cycle mid_at.
    task automatic run_stream(input logic [15:0] v, input logic [7:0] l, input int mid_at,
                              input bit range_chk);
        int   ones;
        int   cyc;
        logic b;
        ones = 0;
        for (int i = 0; i < int'(l); i++) begin
            b = model_bit(v, m_lfsr);
            exp_bits.push_back(b);
            ones += int'(b);
            m_lfsr = lfsr_step(m_lfsr);
        end
        if (ones > 255) ones = 255;
        exp_ones.push_back(ones[7:0]);
        VALUE = v;
        LEN   = l;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        cyc = 1;
        while (DONE !== 1'b1 && cyc <= int'(l) + 4) begin
            if (cyc == mid_at) begin
                START = 1'b1;
                VALUE = 16'h0000;
                LEN   = 8'd3;
            end else begin
                START = 1'b0;
            end
            @(posedge CLK);
            #1;
            cyc++;
        end
        START = 1'b0;
        check("done_cycle", cyc, int'(l) + 1);
        if (range_chk) begin
            total++;
            if (ONES < 8'd70 || ONES > 8'd130) begin
                bad++;
                $display("FAIL ones_range: got %0d expected 70..130", ONES);
            end
            agg_dut   += int'(ONES);
            agg_model += ones;
        end
        @(posedge CLK);
        #1;
        check("done_single_pulse", DONE, 0);
        check("idle_after_done", BUSY, 0);
        check("ones_hold", ONES, ones);
    endtask

    initial begin
        int k;
        INIT  = 1'b1;
        START = 1'b0;
        VALUE = 16'h0;
        LEN   = 8'h0;
        m_lfsr    = 16'hACE1;
        agg_model = 0;
        agg_dut   = 0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_out", OUT, 0);
        check("rst_valid", VALID, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_ones", ONES, 0);
        check("rst_lfsr", dut.u_lfsr.Q, 16'hACE1);
        INIT = 1'b0;
        @(posedge CLK);
        #1;

        // VALUE=0: all zeros, DONE at cycle 11.
        run_stream(16'h0000, 8'd10, 0, 1'b0);
        // VALUE=all-ones: every bit 1, ONES=255.
        run_stream(16'hFFFF, 8'd255, 0, 1'b0);
        // LEN=0: no bits, DONE one cycle after START.
        run_stream(16'h1234, 8'd0, 0, 1'b0);
        // A quarter-probability stream.
        run_stream(16'h4000, 8'd40, 0, 1'b0);
        // Twenty back-to-back half-probability streams.
        for (int s = 0; s < 20; s++) begin
            run_stream(16'h8000, 8'd200, 0, 1'b1);
        end
        check("aggregate_ones", agg_dut, agg_model);
        // START mid-stream with a different VALUE must be ignored.
        run_stream(16'h8000, 8'd20, 5, 1'b0);

        // Abort with INIT on the 5th VALID of a LEN=50 stream.
        for (int i = 0; i < 5; i++) begin
            exp_bits.push_back(model_bit(16'h6000, m_lfsr));
            m_lfsr = lfsr_step(m_lfsr);
        end
        VALUE = 16'h6000;
        LEN   = 8'd50;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        k = 1;
        repeat (4) begin
            @(posedge CLK);
            #1;
            k++;
        end
        check("abort_at_valid", VALID, 1);
        INIT = 1'b1;
        @(posedge CLK);
        #1;
        INIT = 1'b0;
        check("abort_valid", VALID, 0);
        check("abort_done", DONE, 0);
        check("abort_busy", BUSY, 0);
        check("abort_ones", ONES, 0);
        check("abort_lfsr", dut.u_lfsr.Q, 16'hACE1);
        check("abort_bits_consumed", exp_bits.size(), 0);
        m_lfsr = 16'hACE1;
        @(posedge CLK);
        #1;
        check("abort_no_late_done", DONE, 0);
        // Stream after abort restarts from the seed.
        run_stream(16'h8000, 8'd16, 0, 1'b0);

        repeat (3) @(posedge CLK);
        #1;
        check("final_bits_empty", exp_bits.size(), 0);
        check("final_ones_empty", exp_ones.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
